// File: rtl/rx_port_reader_pkg.sv
// Shared constants and FSM encoding for the switch receive-port reader.
package rx_port_reader_pkg;

    localparam int PORT_NUB_TOTAL = 4;
    localparam int DATA_WIDTH     = 16;
    localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rx_port_reader_fifo.sv
// Synchronous output FIFO (power-of-two depth); push and pop may coincide at any occupancy.
module rx_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    import rx_port_reader_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_port_reader.sv
// Receive-side reader for one switch output port: round-robin bursts, credit-gated reads, tagged output FIFO.
// Optional word checker enabled by defining RX_CHECK_EN (adds err / err_cnt ports).
module rx_port_reader #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEST       = 0,
    parameter int BURST_MAX  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORT_NUB-1:0]         empty,
    output logic [$clog2(PORT_NUB)-1:0] rd_sel,
    output logic                        rd_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(PORT_NUB)-1:0] out_src,
    output logic                        dbg_state
`ifdef RX_CHECK_EN
    ,
    output logic                        err,
    output logic [15:0]                 err_cnt
`endif
);
    import rx_port_reader_pkg::*;

    localparam int SW = $clog2(PORT_NUB);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state, state_nxt;
    logic [SW-1:0]   rr, rr_nxt;
    logic [SW-1:0]   cur, cur_nxt;
    logic [SW-1:0]   rd_sel_nxt;
    logic            rd_en_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic            rd_en_d;
    logic [SW-1:0]   sel_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [CW:0]     occupancy;
    logic            credit;
    logic            found;
    logic [SW-1:0]   pick;
    logic [SW-1:0]   idx;

    // Reads still owed to the FIFO: the one on rd_en now plus the one whose data is on data_in.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_en} + {{CW{1'b0}}, rd_en_d};
    assign credit    = (occupancy < (CW+1)'(FIFO_DEPTH));
    assign dbg_state = state;

    always_comb begin
        found = 1'b0;
        pick  = rr;
        idx   = '0;
        // Scanning downward lets the source closest to rr win.
        for (int i = PORT_NUB - 1; i >= 0; i--) begin
            idx = SW'((int'(rr) + i) % PORT_NUB);
            if (!empty[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr;
        cur_nxt    = cur;
        burst_nxt  = burst_cnt;
        rd_en_nxt  = 1'b0;
        rd_sel_nxt = rd_sel;
        case (state)
            IDLE: begin
                if (found && credit) begin
                    rd_en_nxt  = 1'b1;
                    rd_sel_nxt = pick;
                    cur_nxt    = pick;
                    burst_nxt  = BW'(1);
                    state_nxt  = BURST;
                end
            end
            BURST: begin
                if (empty[cur] || burst_cnt == BW'(BURST_MAX)) begin
                    rr_nxt    = (cur == SW'(PORT_NUB - 1)) ? '0 : cur + SW'(1);
                    state_nxt = IDLE;
                end else if (credit) begin
                    rd_en_nxt  = 1'b1;
                    rd_sel_nxt = cur;
                    burst_nxt  = burst_cnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            cur       <= '0;
            burst_cnt <= '0;
            rd_en     <= 1'b0;
            rd_sel    <= '0;
            rd_en_d   <= 1'b0;
            sel_d     <= '0;
        end else begin
            state     <= state_nxt;
            rr        <= rr_nxt;
            cur       <= cur_nxt;
            burst_cnt <= burst_nxt;
            rd_en     <= rd_en_nxt;
            rd_sel    <= rd_sel_nxt;
            rd_en_d   <= rd_en;
            sel_d     <= rd_sel;
        end
    end

    // Output stream: a word transfers on any cycle where out_valid and out_ready are both high;
    // out_valid/out_data/out_src depend only on FIFO state, never combinationally on out_ready.
    rx_fifo #(
        .WIDTH (SW + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_en_d),
        .pop   (out_valid && out_ready),
        .wdata ({sel_d, data_in}),
        .rdata ({out_src, out_data}),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

`ifdef RX_CHECK_EN
    logic [31:0] exp_word;
    logic        mismatch;

    assign exp_word = 32'(sel_d) * 32'd10 + 32'(DEST);
    assign mismatch = rd_en_d && (data_in != exp_word[DATA_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_port_reader.sv
// Scoreboard bench for rx_port_reader with a behavioural switch read port; define RX_CHECK_EN to cover the checker.
module tb_rx_port_reader;

    localparam int PN = 4;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int W  = SW + DW;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [PN-1:0] empty;
    logic [SW-1:0] rd_sel;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_src;
    logic          dbg_state;
`ifdef RX_CHECK_EN
    logic          err;
    logic [15:0]   err_cnt;
`endif

    rx_port_reader #(
        .PORT_NUB   (PN),
        .DATA_WIDTH (DW),
        .DEST       (0),
        .BURST_MAX  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .rd_sel    (rd_sel),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .dbg_state (dbg_state)
`ifdef RX_CHECK_EN
        ,
        .err       (err),
        .err_cnt   (err_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] src_q [PN][$];
    logic [SW-1:0] sel_log[$];
    logic [DW-1:0] stash;
    int            pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void update_empty();
        for (int s = 0; s < PN; s++) begin
            empty[s] = (src_q[s].size() == 0);
        end
    endfunction

    // One clock of the switch model: the queue pops when rd_en is seen, data follows a cycle later.
    task automatic step();
        @(posedge clk);
        #1;
        data_in = stash;
        if (rd_en === 1'b1) begin
            pulses++;
            sel_log.push_back(rd_sel);
            check("read_nonempty", 32'(src_q[rd_sel].size() > 0), 32'd1);
            if (src_q[rd_sel].size() > 0) begin
                stash = src_q[rd_sel].pop_front();
            end
        end
        update_empty();
    endtask

    task automatic load(input int s, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            src_q[s].push_back(DW'(base + k));
        end
        update_empty();
    endtask

    task automatic expect_word(input int s, input int d);
        exp_q.push_back({SW'(s), DW'(d)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) step();
    endtask

    // scoreboard monitor
    task automatic monitor_loop();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_word: got src=%0d data=%0d expected no word", out_src, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_src", 32'(out_src), 32'(e[W-1:DW]));
                    check("out_data", 32'(out_data), 32'(e[DW-1:0]));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        empty     = '1;
        data_in   = '0;
        out_ready = 1'b1;
        stash     = '0;
        pulses    = 0;
        fork
            monitor_loop();
        join_none

        // reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        step();

        // all four sources, 10 words each: 4-word bursts in order 0,1,2,3, then 2-word tails
        for (int s = 0; s < PN; s++) load(s, 10, s * 10);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < PN; s++)
                for (int k = 0; k < 4; k++) expect_word(s, s * 10 + r * 4 + k);
        for (int s = 0; s < PN; s++)
            for (int k = 0; k < 2; k++) expect_word(s, s * 10 + 8 + k);
        wait_drain("drain_all_sources", 400);

        // single source 2, three words, with idle latency
        pulses = 0;
        sel_log.delete();
        load(2, 3, 20);
        for (int k = 0; k < 3; k++) expect_word(2, 20 + k);
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("first_out_latency", 32'(n), 32'd3);
        wait_drain("drain_single_source", 50);
        check("single_pulses", 32'(pulses), 32'd3);
        for (int k = 0; k < 3; k++) check("single_rd_sel", 32'(sel_log[k]), 32'd2);

        // wrap-around: rr is 3, only source 0 has data, then rr must be 1
        load(0, 1, 0);
        expect_word(0, 0);
        wait_drain("drain_wrap", 50);
        load(0, 1, 1);
        load(1, 1, 11);
        expect_word(1, 11);
        expect_word(0, 1);
        wait_drain("drain_after_wrap", 50);

        // backpressure: credits allow exactly FIFO_DEPTH reads
        out_ready = 1'b0;
        pulses = 0;
        load(3, 8, 30);
        for (int k = 0; k < 8; k++) expect_word(3, 30 + k);
        repeat (20) step();
        check("bp_pulses", 32'(pulses), 32'd4);
        check("bp_rd_en_low", 32'(rd_en), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_data", 32'(out_data), 32'd30);
        out_ready = 1'b1;
        wait_drain("drain_backpressure", 100);
        check("bp_total_pulses", 32'(pulses), 32'd8);

        // reset mid-burst with a word in flight; rr is 2 beforehand
        load(1, 1, 10);
        expect_word(1, 10);
        wait_drain("drain_pre_reset", 50);
        pulses = 0;
        load(2, 6, 20);
        n = 0;
        while (pulses < 2 && n < 10) begin
            step();
            n++;
        end
        check("mid_burst_reached", 32'(pulses), 32'd2);
        rst = 1'b1;
        step();
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        for (int s = 0; s < PN; s++) src_q[s].delete();
        update_empty();
        stash = '0;
        sel_log.delete();
        rst = 1'b0;
        load(0, 2, 0);
        load(3, 1, 30);
        expect_word(0, 0);
        expect_word(0, 1);
        expect_word(3, 30);
        wait_drain("drain_after_reset", 50);
        check("post_rst_first_sel", 32'(sel_log[0]), 32'd0);

`ifdef RX_CHECK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("chk_rst_err", 32'(err), 32'd0);
        check("chk_rst_err_cnt", 32'(err_cnt), 32'd0);
        load(1, 1, 99);
        expect_word(1, 99);
        wait_drain("drain_bad_word", 50);
        check("chk_err_set", 32'(err), 32'd1);
        check("chk_err_cnt_one", 32'(err_cnt), 32'd1);
        load(1, 1, 10);
        expect_word(1, 10);
        wait_drain("drain_good_word", 50);
        check("chk_err_sticky", 32'(err), 32'd1);
        check("chk_err_cnt_held", 32'(err_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
